// File: rtl/bsg_two_fifo_pkg.sv
// bsg_two_fifo_pkg
//   Shared definitions for the two-entry FIFO controller and its storage.
//   Holds the entry count, the pointer width, the 9-bit data type and the
//   occupancy encoding that is decoded from the empty/full flags.
package bsg_two_fifo_pkg;

  localparam int unsigned els_lp       = 2;
  localparam int unsigned ptr_width_lp = 1;

  typedef logic [8:0]              data_t;
  typedef logic [ptr_width_lp-1:0] ptr_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Occupancy is fully described by the two flags; both set never occurs.
  function automatic occ_e occ_decode(input logic empty, input logic full);
    occ_e occ;
    if (empty)     occ = OCC_EMPTY;
    else if (full) occ = OCC_FULL;
    else           occ = OCC_ONE;
    return occ;
  endfunction

endpackage

// File: rtl/bsg_two_fifo_storage_w9.sv
// bsg_two_fifo_storage_w9
//   Flop array holding the FIFO entries (els_p x 9 bits). Not reset.
// Ports:
//   clk_i     - clock; writes on posedge
//   w_v_i     - write strobe
//   w_addr_i  - write entry index
//   w_data_i  - write data
//   r_addr_i  - read entry index (combinational read)
//   r_data_o  - read data
module bsg_two_fifo_storage_w9
  import bsg_two_fifo_pkg::*;
#(
  parameter int unsigned els_p = els_lp
) (
  input  logic  clk_i,
  input  logic  w_v_i,
  input  ptr_t  w_addr_i,
  input  data_t w_data_i,
  input  ptr_t  r_addr_i,
  output data_t r_data_o
);

  data_t mem_q [els_p];

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < els_p; i++) begin
      if (w_v_i && (w_addr_i == ptr_t'(i))) begin
        mem_q[i] <= w_data_i;
      end
    end
  end

  always_comb begin
    r_data_o = mem_q[r_addr_i];
  end

endmodule

// File: rtl/bsg_two_fifo_ctrl_w9.sv
// bsg_two_fifo_ctrl_w9
//   Two-entry, 9-bit FIFO: ready/valid producer side, valid/yumi consumer
//   side. ready_o depends only on registered state (plus reset), so there is
//   no combinational path from yumi_i to ready_o.
//   Optional macro BSG_TWO_FIFO_CTRL_BYPASS_EN: when the FIFO is empty, v_i
//   and data_i are presented on v_o/data_o in the same cycle; if the consumer
//   takes that word immediately it is never written.
// Ports:
//   clk_i    - clock
//   reset_i  - synchronous active-high reset
//   v_i      - producer valid
//   data_i   - producer data
//   ready_o  - FIFO can accept (enqueue when v_i & ready_o)
//   v_o      - head entry valid
//   data_o   - head entry data
//   yumi_i   - consumer takes head (ignored while nothing is valid)
module bsg_two_fifo_ctrl_w9
  import bsg_two_fifo_pkg::*;
#(
  parameter int unsigned width_p = 9,
  parameter int unsigned els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  ptr_t  wptr_q, wptr_d;
  ptr_t  rptr_q, rptr_d;
  logic  empty_q, empty_d;
  logic  full_q, full_d;
  logic  enq, deq;
  occ_e  occ;
  data_t r_data;

  bsg_two_fifo_storage_w9 #(
    .els_p(els_p)
  ) storage (
    .clk_i    (clk_i),
    .w_v_i    (enq),
    .w_addr_i (wptr_q),
    .w_data_i (data_i),
    .r_addr_i (rptr_q),
    .r_data_o (r_data)
  );

  always_comb begin
    occ     = occ_decode(empty_q, full_q);
    ready_o = ~full_q & ~reset_i;
    // Dequeue from storage only when a stored entry exists; this also drops
    // an illegal yumi_i while empty.
    deq     = yumi_i & ~empty_q & ~reset_i;
`ifdef BSG_TWO_FIFO_CTRL_BYPASS_EN
    v_o     = ~reset_i & (~empty_q | v_i);
    data_o  = empty_q ? data_i : r_data;
    // A word consumed straight through the bypass is never stored.
    enq     = v_i & ready_o & ~(empty_q & yumi_i);
`else
    v_o     = ~empty_q & ~reset_i;
    data_o  = r_data;
    enq     = v_i & ready_o;
`endif
    wptr_d  = wptr_q ^ ptr_t'(enq);
    rptr_d  = rptr_q ^ ptr_t'(deq);
    empty_d = (empty_q & ~enq) | (deq & ~enq & (occ == OCC_ONE));
    full_d  = (full_q & ~deq) | (enq & ~deq & (occ == OCC_ONE));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

endmodule

// File: tb/tb_bsg_two_fifo_ctrl_w9.sv
module tb_bsg_two_fifo_ctrl_w9;

`ifdef BSG_TWO_FIFO_CTRL_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       v_i = 1'b0;
  logic [8:0] data_i = '0;
  logic       yumi_i = 1'b0;
  logic       ready_o;
  logic       v_o;
  logic [8:0] data_o;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference contents, head at index 0.
  logic [8:0] model_q [$];

  bsg_two_fifo_ctrl_w9 #(
    .width_p(9),
    .els_p  (2)
  ) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .v_i    (v_i),
    .data_i (data_i),
    .ready_o(ready_o),
    .v_o    (v_o),
    .data_o (data_o),
    .yumi_i (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [8:0] got, input logic [8:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%03h expected=0x%03h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, check outputs
  // mid-cycle against the queue model, then advance the model to what the
  // coming edge commits.
  task automatic step(input logic rst, input logic v, input logic [8:0] d, input logic y);
    logic       exp_ready;
    logic       exp_v;
    logic [8:0] exp_data;
    logic       through;
    logic       do_enq;
    logic       do_deq;
    @(posedge clk_i);
    #1;
    reset_i = rst;
    v_i     = v;
    data_i  = d;
    yumi_i  = y;
    #2;
    exp_ready = !rst && (model_q.size() < 2);
    exp_v     = !rst && ((model_q.size() > 0) || (BypassEn && v));
    exp_data  = (model_q.size() > 0) ? model_q[0] : d;
    check_val("ready_o", {8'b0, ready_o}, {8'b0, exp_ready});
    check_val("v_o", {8'b0, v_o}, {8'b0, exp_v});
    if (exp_v) check_val("data_o", data_o, exp_data);

    if (rst) begin
      model_q.delete();
    end else begin
      through = BypassEn && (model_q.size() == 0) && v && y;
      do_enq  = v && (model_q.size() < 2) && !through;
      do_deq  = y && (model_q.size() > 0);
      if (do_deq) void'(model_q.pop_front());
      if (do_enq) model_q.push_back(d);
    end
  endtask

  initial begin
    // Reset and single enqueue of 0x1A5.
    step(1'b1, 1'b0, 9'h000, 1'b0);
    step(1'b1, 1'b1, 9'h0AA, 1'b1);
    step(1'b0, 1'b1, 9'h1A5, 1'b0);
    step(1'b0, 1'b0, 9'h000, 1'b0);
    step(1'b0, 1'b0, 9'h000, 1'b1);
    step(1'b0, 1'b0, 9'h000, 1'b0);

    // Fill, attempt a third write, drain.
    step(1'b0, 1'b1, 9'h001, 1'b0);
    step(1'b0, 1'b1, 9'h1FF, 1'b0);
    step(1'b0, 1'b1, 9'h0AA, 1'b0);
    step(1'b0, 1'b0, 9'h000, 1'b1);
    step(1'b0, 1'b0, 9'h000, 1'b1);
    step(1'b0, 1'b0, 9'h000, 1'b0);
    // yumi while empty must be ignored.
    step(1'b0, 1'b0, 9'h000, 1'b1);

    // Streaming at occupancy 1.
    step(1'b0, 1'b1, 9'd0, 1'b0);
    for (int i = 1; i <= 20; i++) step(1'b0, 1'b1, 9'(i), 1'b1);
    step(1'b0, 1'b0, 9'h000, 1'b1);
    step(1'b0, 1'b0, 9'h000, 1'b0);

    // Full FIFO, reset with v_i high, then recover.
    step(1'b0, 1'b1, 9'h011, 1'b0);
    step(1'b0, 1'b1, 9'h022, 1'b0);
    step(1'b1, 1'b1, 9'h033, 1'b0);
    step(1'b0, 1'b1, 9'h055, 1'b0);
    step(1'b0, 1'b0, 9'h000, 1'b1);
    step(1'b0, 1'b0, 9'h000, 1'b0);

    // Consumer stall with changing input data ignored by the held head.
    step(1'b0, 1'b1, 9'h123, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 9'($urandom), 1'b0);
    step(1'b0, 1'b0, 9'h000, 1'b1);

    // Empty FIFO with v_i and yumi_i together.
    step(1'b0, 1'b1, 9'h0F0, 1'b1);
    step(1'b0, 1'b0, 9'h000, 1'b0);
    step(1'b0, 1'b0, 9'h000, 1'b1);

    // Randomized traffic, occasional reset.
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0),
           9'($urandom),
           ($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
